systolic_link_host: RTL and testbench

Host-side endpoint of the systolic array's nibble-serial link. It takes whole 16-bit column/row words plus their 4-bit control nibbles from a host, and serializes them onto the 4-bit data and 1-bit control lanes that feed the first array cell. It also deserializes the frames returning from the last cell and presents them to the host as whole words. The block shares the array's 4-cycle frame phase and its reset, so host and cells count frames in lockstep.

---
 rtl/systolic_link_host.sv | 198 +++++++++++++++++++
 tb/tb_systolic_link_host.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_link_host.sv
// systolic_link_host
// Host-side endpoint of the systolic array's nibble-serial link. Whole 16-bit
// column/row words with 4-bit control nibbles are serialized MSB nibble first
// over a 4-cycle frame. Frames returning from the last cell are deserialized
// back into whole words. The frame phase runs in lockstep with the array,
// because both share the same clock and reset.
//
// Ports
//   clk, rst_n                    clock and asynchronous active-low reset
//   tx_valid / tx_ready           host handshake (tx_ready = holding register empty)
//   tx_col, tx_col_ctrl           column word and control nibble (ctrl[3:2] addr, [1:0] fmt)
//   tx_row, tx_row_ctrl           row word and control nibble
//   col_out, col_ctrl_out         column data/control lanes into the array
//   row_out, row_ctrl_out         row data/control lanes into the array
//   col_in, col_ctrl_in           column return lanes from the array
//   row_in, row_ctrl_in           row return lanes from the array
//   rx_valid                      one-cycle pulse: returned frame belongs to a real tx frame
//   rx_col, rx_col_ctrl           returned column word and control
//   rx_row, rx_row_ctrl           returned row word and control
//   phase                         frame phase 0..3
//
// LAG must be at least 1.

module systolic_link_host #(
    parameter int LAG = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [15:0] tx_col,
    input  logic [3:0]  tx_col_ctrl,
    input  logic [15:0] tx_row,
    input  logic [3:0]  tx_row_ctrl,
    output logic [3:0]  col_out,
    output logic        col_ctrl_out,
    output logic [3:0]  row_out,
    output logic        row_ctrl_out,
    input  logic [3:0]  col_in,
    input  logic        col_ctrl_in,
    input  logic [3:0]  row_in,
    input  logic        row_ctrl_in,
    output logic        rx_valid,
    output logic [15:0] rx_col,
    output logic [3:0]  rx_col_ctrl,
    output logic [15:0] rx_row,
    output logic [3:0]  rx_row_ctrl,
    output logic [1:0]  phase
);

    typedef enum logic {
        HOLD_EMPTY,
        HOLD_FULL
    } holdState_t;

    holdState_t   holdState_q, holdState_d;
    logic [1:0]   phase_q;
    logic         frameEdge;
    logic         txFire;
    logic         loadReal;
    logic [39:0]  txFrame;
    logic [39:0]  hold_q, hold_d;
    logic [39:0]  frame_q, frame_d;
    logic [15:0]  frameCol, frameRow;
    logic [3:0]   frameColCtrl, frameRowCtrl;
    logic [1:0]   nibSel;
    logic [11:0]  colShift_q, rowShift_q;
    logic [2:0]   colCtrlShift_q, rowCtrlShift_q;
    logic [15:0]  rxCol_q, rxRow_q;
    logic [3:0]   rxColCtrl_q, rxRowCtrl_q;
    logic [LAG:0] validSr_q;
    logic         rxValid_q;

    // Frame layout: {col word, col ctrl, row word, row ctrl}. All-zero is the idle frame.
    assign txFrame      = {tx_col, tx_col_ctrl, tx_row, tx_row_ctrl};
    assign frameCol     = frame_q[39:24];
    assign frameColCtrl = frame_q[23:20];
    assign frameRow     = frame_q[19:4];
    assign frameRowCtrl = frame_q[3:0];

    assign frameEdge = (phase_q == 2'd3);
    assign txFire    = tx_valid && tx_ready;
    assign phase     = phase_q;

    // Free-running frame phase, counting 0..3 in lockstep with the array cells.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 2'd0;
        end else begin
            phase_q <= phase_q + 2'd1;
        end
    end

    // Holding register and frame register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holdState_q <= HOLD_EMPTY;
            hold_q      <= '0;
            frame_q     <= '0;
        end else begin
            holdState_q <= holdState_d;
            hold_q      <= hold_d;
            frame_q     <= frame_d;
        end
    end

    // At a frame edge a waiting held word has priority over a same-edge
    // transfer. A same-edge transfer bypasses the holding register straight
    // into the frame. With neither present, an idle frame is sent.
    // tx_ready is low whenever the holding register is full, so a transfer
    // can never collide with a held word.
    always_comb begin
        holdState_d = holdState_q;
        hold_d      = hold_q;
        frame_d     = frame_q;
        loadReal    = 1'b0;
        if (frameEdge) begin
            if (holdState_q == HOLD_FULL) begin
                frame_d     = hold_q;
                hold_d      = '0;
                holdState_d = HOLD_EMPTY;
                loadReal    = 1'b1;
            end else if (txFire) begin
                frame_d  = txFrame;
                loadReal = 1'b1;
            end else begin
                frame_d = '0;
            end
        end else if (txFire) begin
            hold_d      = txFrame;
            holdState_d = HOLD_FULL;
        end
    end

    // Handshake output of the holding register.
    always_comb begin
        tx_ready = (holdState_q == HOLD_EMPTY);
    end

    // Lanes are muxed straight from the frame register. Phase 0 selects the
    // most significant nibble and control bit 3.
    always_comb begin
        nibSel       = 2'd3 - phase_q;
        col_out      = frameCol[{nibSel, 2'b00} +: 4];
        row_out      = frameRow[{nibSel, 2'b00} +: 4];
        col_ctrl_out = frameColCtrl[nibSel];
        row_ctrl_out = frameRowCtrl[nibSel];
    end

    // Deserializer: shift during phases 0..2. At the frame edge, concatenate
    // the shifted bits with the live phase-3 nibble. Idle frames update rx_*
    // too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            colShift_q     <= '0;
            rowShift_q     <= '0;
            colCtrlShift_q <= '0;
            rowCtrlShift_q <= '0;
            rxCol_q        <= '0;
            rxRow_q        <= '0;
            rxColCtrl_q    <= '0;
            rxRowCtrl_q    <= '0;
        end else if (frameEdge) begin
            rxCol_q     <= {colShift_q, col_in};
            rxRow_q     <= {rowShift_q, row_in};
            rxColCtrl_q <= {colCtrlShift_q, col_ctrl_in};
            rxRowCtrl_q <= {rowCtrlShift_q, row_ctrl_in};
        end else begin
            colShift_q     <= {colShift_q[7:0], col_in};
            rowShift_q     <= {rowShift_q[7:0], row_in};
            colCtrlShift_q <= {colCtrlShift_q[1:0], col_ctrl_in};
            rowCtrlShift_q <= {rowCtrlShift_q[1:0], row_ctrl_in};
        end
    end

    // Valid tracking. A real frame enters bit 0 on the edge it is loaded.
    // The pulse is taken from the oldest bit as it stood before this edge.
    // That makes it line up with the returned frame captured LAG+1 frames
    // after the load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validSr_q <= '0;
            rxValid_q <= 1'b0;
        end else if (frameEdge) begin
            validSr_q <= {validSr_q[LAG-1:0], loadReal};
            rxValid_q <= validSr_q[LAG];
        end else begin
            rxValid_q <= 1'b0;
        end
    end

    assign rx_valid    = rxValid_q;
    assign rx_col      = rxCol_q;
    assign rx_col_ctrl = rxColCtrl_q;
    assign rx_row      = rxRow_q;
    assign rx_row_ctrl = rxRowCtrl_q;

endmodule

// File: tb/tb_systolic_link_host.sv
// Directed bench for systolic_link_host. One instance runs with LAG=1 and
// another with LAG=3. Both share the host-side inputs, and each is closed by
// an echo model of the cells: every received frame is returned LAG frames
// later.

module tb_systolic_link_host;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_valid;
    logic [15:0] tx_col, tx_row;
    logic [3:0]  tx_col_ctrl, tx_row_ctrl;

    logic        tx_ready1, col_ctrl_out1, row_ctrl_out1, col_ctrl_in1, row_ctrl_in1, rx_valid1;
    logic [3:0]  col_out1, row_out1, col_in1, row_in1, rx_col_ctrl1, rx_row_ctrl1;
    logic [15:0] rx_col1, rx_row1;
    logic [1:0]  phase1;

    logic        tx_ready3, col_ctrl_out3, row_ctrl_out3, col_ctrl_in3, row_ctrl_in3, rx_valid3;
    logic [3:0]  col_out3, row_out3, col_in3, row_in3, rx_col_ctrl3, rx_row_ctrl3;
    logic [15:0] rx_col3, rx_row3;
    logic [1:0]  phase3;

    int assertCount = 0;
    int failCount   = 0;
    int cycleCount  = 0;
    int t0;
    int waits;

    logic [1:0]  tbPhase;
    logic [11:0] capC1, capR1, capC3, capR3;
    logic [2:0]  capCc1, capRc1, capCc3, capRc3;
    logic [39:0] echo1, echo3a, echo3b, echo3c;

    logic [39:0] rxQ1[$];
    int          rxT1[$];
    logic [39:0] rxQ3[$];
    int          rxT3[$];

    logic [31:0] s2Lanes = 32'hA1B2C3D4;
    logic [7:0]  s5Ctrl  = 8'b10_01_10_01;
    logic [52:0] allOut1;
    logic [9:0]  lanes1;

    assign allOut1 = {col_out1, col_ctrl_out1, row_out1, row_ctrl_out1, rx_valid1,
                      rx_col1, rx_col_ctrl1, rx_row1, rx_row_ctrl1, phase1};
    assign lanes1  = {col_out1, col_ctrl_out1, row_out1, row_ctrl_out1};

    always #5 clk = ~clk;

    systolic_link_host #(.LAG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready1),
        .tx_col(tx_col), .tx_col_ctrl(tx_col_ctrl), .tx_row(tx_row), .tx_row_ctrl(tx_row_ctrl),
        .col_out(col_out1), .col_ctrl_out(col_ctrl_out1), .row_out(row_out1), .row_ctrl_out(row_ctrl_out1),
        .col_in(col_in1), .col_ctrl_in(col_ctrl_in1), .row_in(row_in1), .row_ctrl_in(row_ctrl_in1),
        .rx_valid(rx_valid1), .rx_col(rx_col1), .rx_col_ctrl(rx_col_ctrl1),
        .rx_row(rx_row1), .rx_row_ctrl(rx_row_ctrl1), .phase(phase1)
    );

    systolic_link_host #(.LAG(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready3),
        .tx_col(tx_col), .tx_col_ctrl(tx_col_ctrl), .tx_row(tx_row), .tx_row_ctrl(tx_row_ctrl),
        .col_out(col_out3), .col_ctrl_out(col_ctrl_out3), .row_out(row_out3), .row_ctrl_out(row_ctrl_out3),
        .col_in(col_in3), .col_ctrl_in(col_ctrl_in3), .row_in(row_in3), .row_ctrl_in(row_ctrl_in3),
        .rx_valid(rx_valid3), .rx_col(rx_col3), .rx_col_ctrl(rx_col_ctrl3),
        .rx_row(rx_row3), .rx_row_ctrl(rx_row_ctrl3), .phase(phase3)
    );

    function automatic logic [3:0] nibAt(input logic [15:0] w, input logic [1:0] p);
        case (p)
            2'd0:    return w[15:12];
            2'd1:    return w[11:8];
            2'd2:    return w[7:4];
            default: return w[3:0];
        endcase
    endfunction

    function automatic logic bitAt(input logic [3:0] c, input logic [1:0] p);
        case (p)
            2'd0:    return c[3];
            2'd1:    return c[2];
            2'd2:    return c[1];
            default: return c[0];
        endcase
    endfunction

    // Cell models: capture each outgoing frame and replay it LAG frames later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbPhase <= 2'd0;
            capC1 <= '0; capR1 <= '0; capCc1 <= '0; capRc1 <= '0;
            capC3 <= '0; capR3 <= '0; capCc3 <= '0; capRc3 <= '0;
            echo1 <= '0; echo3a <= '0; echo3b <= '0; echo3c <= '0;
        end else begin
            tbPhase <= tbPhase + 2'd1;
            capC1  <= {capC1[7:0], col_out1};
            capR1  <= {capR1[7:0], row_out1};
            capCc1 <= {capCc1[1:0], col_ctrl_out1};
            capRc1 <= {capRc1[1:0], row_ctrl_out1};
            capC3  <= {capC3[7:0], col_out3};
            capR3  <= {capR3[7:0], row_out3};
            capCc3 <= {capCc3[1:0], col_ctrl_out3};
            capRc3 <= {capRc3[1:0], row_ctrl_out3};
            if (tbPhase == 2'd3) begin
                echo1  <= {capC1, col_out1, capCc1, col_ctrl_out1, capR1, row_out1, capRc1, row_ctrl_out1};
                echo3a <= {capC3, col_out3, capCc3, col_ctrl_out3, capR3, row_out3, capRc3, row_ctrl_out3};
                echo3b <= echo3a;
                echo3c <= echo3b;
            end
        end
    end

    assign col_in1      = nibAt(echo1[39:24], tbPhase);
    assign col_ctrl_in1 = bitAt(echo1[23:20], tbPhase);
    assign row_in1      = nibAt(echo1[19:4], tbPhase);
    assign row_ctrl_in1 = bitAt(echo1[3:0], tbPhase);
    assign col_in3      = nibAt(echo3c[39:24], tbPhase);
    assign col_ctrl_in3 = bitAt(echo3c[23:20], tbPhase);
    assign row_in3      = nibAt(echo3c[19:4], tbPhase);
    assign row_ctrl_in3 = bitAt(echo3c[3:0], tbPhase);

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Record every rx_valid pulse with its frame and cycle stamp.
    always @(negedge clk) begin
        if (rx_valid1) begin
            rxQ1.push_back({rx_col1, rx_col_ctrl1, rx_row1, rx_row_ctrl1});
            rxT1.push_back(cycleCount);
        end
        if (rx_valid3) begin
            rxQ3.push_back({rx_col3, rx_col_ctrl3, rx_row3, rx_row_ctrl3});
            rxT3.push_back(cycleCount);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] c, input logic [3:0] cc,
                                 input logic [15:0] r, input logic [3:0] rc);
        tx_valid    = v;
        tx_col      = c;
        tx_col_ctrl = cc;
        tx_row      = r;
        tx_row_ctrl = rc;
    endtask

    task automatic alignPhase(input logic [1:0] p);
        for (int n = 0; n < 8 && tbPhase != p; n++) tick();
    endtask

    task automatic clearQueues();
        rxQ1.delete(); rxT1.delete(); rxQ3.delete(); rxT3.delete();
    endtask

    // Present a pair in phase 3 so it is accepted on the frame edge itself.
    task automatic sendOnEdge(input logic [15:0] c, input logic [3:0] cc,
                              input logic [15:0] r, input logic [3:0] rc);
        alignPhase(2'd3);
        applyStimulus(1'b1, c, cc, r, rc);
        checkOutput("readyBeforeSend", 64'(tx_ready1), 64'd1);
        tick();
        applyStimulus(1'b0, 16'h0, 4'h0, 16'h0, 4'h0);
        t0 = cycleCount;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 16'h0, 4'h0, 16'h0, 4'h0);

        $display("[TB] reset release");
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("resetOutputs", 64'(allOut1), 64'd0);
            checkOutput("resetReady", 64'(tx_ready1), 64'd1);
        end
        rst_n = 1'b1;
        checkOutput("phaseRelease", 64'(phase1), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkOutput("phaseSequence", 64'(phase1), 64'(i % 4));
        end

        $display("[TB] single frame");
        clearQueues();
        sendOnEdge(16'hABCD, 4'h0, 16'h1234, 4'h0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("s2Lanes", {56'd0, col_out1, row_out1}, 64'(s2Lanes[31 - 8*k -: 8]));
            if (k < 3) tick();
        end
        repeat (4) tick();
        checkOutput("s2NoEarlyValid", 64'(rx_valid1), 64'd0);
        tick();
        checkOutput("s2Valid", 64'(rx_valid1), 64'd1);
        checkOutput("s2RxCol", 64'(rx_col1), 64'hABCD);
        checkOutput("s2RxRow", 64'(rx_row1), 64'h1234);
        checkOutput("s2Latency", 64'(cycleCount - t0), 64'd8);
        tick();
        checkOutput("s2ValidPulse", 64'(rx_valid1), 64'd0);

        $display("[TB] back-to-back with backpressure");
        repeat (8) tick();
        clearQueues();
        alignPhase(2'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'hC0C0 + 16'(i), 4'(i), 16'h3E00 + 16'(i), 4'(15 - i));
            waits = 0;
            while (!tx_ready1 && waits < 8) begin
                tick();
                waits++;
            end
            checkOutput("s3ReadyWait", 64'(tx_ready1), 64'd1);
            if (i > 0) checkOutput("s3ReadyPhase", 64'(tbPhase), 64'd0);
            tick();
            if (i == 0) checkOutput("s3HoldFullReady", 64'(tx_ready1), 64'd0);
        end
        applyStimulus(1'b0, 16'h0, 4'h0, 16'h0, 4'h0);
        repeat (24) tick();
        checkOutput("s3PulseCount", 64'(rxQ1.size()), 64'd5);
        for (int j = 0; j < rxQ1.size() && j < 5; j++) begin
            checkOutput("s3Frame", 64'(rxQ1[j]),
                        64'({16'hC0C0 + 16'(j), 4'(j), 16'h3E00 + 16'(j), 4'(15 - j)}));
            if (j > 0) checkOutput("s3Spacing", 64'(rxT1[j] - rxT1[j-1]), 64'd4);
        end

        $display("[TB] idle gap");
        clearQueues();
        sendOnEdge(16'h1111, 4'h0, 16'h2222, 4'h0);
        repeat (3) tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            checkOutput("s4IdleLanes", 64'(lanes1), 64'd0);
        end
        applyStimulus(1'b1, 16'h3333, 4'h0, 16'h4444, 4'h0);
        tick();
        applyStimulus(1'b0, 16'h0, 4'h0, 16'h0, 4'h0);
        repeat (16) tick();
        checkOutput("s4PulseCount", 64'(rxQ1.size()), 64'd2);
        if (rxQ1.size() >= 2) begin
            checkOutput("s4First", 64'(rxQ1[0]), 64'({16'h1111, 4'h0, 16'h2222, 4'h0}));
            checkOutput("s4Second", 64'(rxQ1[1]), 64'({16'h3333, 4'h0, 16'h4444, 4'h0}));
            checkOutput("s4Spacing", 64'(rxT1[1] - rxT1[0]), 64'd12);
        end

        $display("[TB] control serialization");
        clearQueues();
        sendOnEdge(16'h0F0F, 4'hA, 16'h00FF, 4'h5);
        for (int k = 0; k < 4; k++) begin
            checkOutput("s5CtrlLanes", {62'd0, col_ctrl_out1, row_ctrl_out1}, 64'(s5Ctrl[7 - 2*k -: 2]));
            if (k < 3) tick();
        end
        repeat (12) tick();
        checkOutput("s5PulseCount", 64'(rxQ1.size()), 64'd1);
        if (rxQ1.size() >= 1)
            checkOutput("s5Frame", 64'(rxQ1[0]), 64'({16'h0F0F, 4'hA, 16'h00FF, 4'h5}));

        $display("[TB] mid-frame reset");
        repeat (8) tick();
        sendOnEdge(16'hBEEF, 4'h3, 16'hCAFE, 4'hC);
        tick();
        tick();
        checkOutput("s6PhaseBeforeReset", 64'(tbPhase), 64'd2);
        checkOutput("s6LaneInFlight", 64'(col_out1), 64'hE);
        rst_n = 1'b0;
        #1;
        checkOutput("s6ResetOutputs", 64'(allOut1), 64'd0);
        checkOutput("s6ResetReady", 64'(tx_ready1), 64'd1);
        tick();
        tick();
        rst_n = 1'b1;
        clearQueues();
        repeat (20) tick();
        checkOutput("s6NoValidLag1", 64'(rxQ1.size()), 64'd0);
        checkOutput("s6NoValidLag3", 64'(rxQ3.size()), 64'd0);

        $display("[TB] LAG=3 variant");
        clearQueues();
        sendOnEdge(16'hABCD, 4'h0, 16'h1234, 4'h0);
        checkOutput("lag3Phase", 64'(phase3), 64'(tbPhase));
        repeat (20) tick();
        checkOutput("lag3PulseCount", 64'(rxQ3.size()), 64'd1);
        if (rxQ3.size() >= 1) begin
            checkOutput("lag3Latency", 64'(rxT3[0] - t0), 64'd16);
            checkOutput("lag3Frame", 64'(rxQ3[0]), 64'({16'hABCD, 4'h0, 16'h1234, 4'h0}));
        end
        checkOutput("lag1PulseCount", 64'(rxQ1.size()), 64'd1);
        if (rxQ1.size() >= 1) checkOutput("lag1Latency", 64'(rxT1[0] - t0), 64'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
